sys_array_output_collector: RTL and testbench

- Sink end of the systolic array's partial-sum path: receives the skewed out_data words leaving the bottom row of sys_array_cell columns (column j of row r arrives one cycle after column j-1).
- De-skews each result row, buffers full rows in a small first-word-fall-through (FWFT) FIFO, and presents them downstream over a valid/ready handshake with frame framing.

---
 rtl/sys_array_output_collector.sv | 169 ++++++++++++++++
 tb/tb_sys_array_output_collector.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_output_collector.sv
// Collects skewed systolic-array column outputs, re-aligns them into rows and streams them via a FWFT FIFO.
// Optional build macro SYS_ARRAY_COLLECTOR_RELU_EN clamps negative words to zero on FIFO write.
module sys_array_output_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ROW_W-1:0]             num_rows,
  input  logic [COLS-1:0]              col_valid,
  input  logic [COLS*2*DATA_WIDTH-1:0] col_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS*2*DATA_WIDTH-1:0] out_row,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         skew_err
);
  localparam int WW = 2*DATA_WIDTH;
  localparam int RW = COLS*WW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [ROW_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  function automatic logic signed [WW-1:0] store_word(input logic signed [WW-1:0] w);
`ifdef SYS_ARRAY_COLLECTOR_RELU_EN
    return w[WW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Stage p0: input register, loaded every cycle
  logic [COLS-1:0]      vld_p0;
  logic signed [WW-1:0] dat_p0 [COLS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= '0;
      for (int j = 0; j < COLS; j++) dat_p0[j] <= '0;
    end else begin
      vld_p0 <= col_valid;
      for (int j = 0; j < COLS; j++) dat_p0[j] <= col_data[j*WW +: WW];
    end
  end

  // De-skew: earlier columns wait so that every column of a row lines up with the last one
  logic [COLS-1:0]      vld_al;
  logic signed [WW-1:0] dat_al [COLS];

  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_direct
      assign vld_al[j] = vld_p0[j];
      assign dat_al[j] = dat_p0[j];
    end else begin : g_delay
      logic                 vld_d [D];
      logic signed [WW-1:0] dat_d [D];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < D; s++) begin
            vld_d[s] <= 1'b0;
            dat_d[s] <= '0;
          end
        end else begin
          vld_d[0] <= vld_p0[j];
          dat_d[0] <= dat_p0[j];
          for (int s = 1; s < D; s++) begin
            vld_d[s] <= vld_d[s-1];
            dat_d[s] <= dat_d[s-1];
          end
        end
      end
      assign vld_al[j] = vld_d[D-1];
      assign dat_al[j] = dat_d[D-1];
    end
  end

  logic [RW-1:0] row_st;
  always_comb begin
    row_st = '0;
    for (int j = 0; j < COLS; j++) row_st[j*WW +: WW] = store_word(dat_al[j]);
  end

  // Stage p1: FIFO write and frame control
  state_t           state;
  logic [ROW_W-1:0] num_q, wr_cnt, rd_cnt;
  logic [AW:0]      wp, rp;
  logic [RW-1:0]    mem [FIFO_DEPTH];
  logic [RW-1:0]    hold_q;
  logic             empty, full, aligned, partial, take, push, pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign aligned = &vld_al;
  assign partial = (|vld_al) && !aligned;
  assign take    = (state == COLLECT) && aligned && (wr_cnt < num_q);
  assign pop     = !empty && out_ready;
  assign push    = take && (!full || pop);

  assign out_valid = !empty;
  assign out_row   = empty ? hold_q : mem[rp[AW-1:0]];
  assign out_last  = !empty && (rd_cnt == num_q - CNT_ONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= row_st;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      num_q    <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wp       <= '0;
      rp       <= '0;
      hold_q   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) wp <= wp + PTR_ONE;
      if (pop) begin
        rp     <= rp + PTR_ONE;
        hold_q <= mem[rp[AW-1:0]];
        rd_cnt <= rd_cnt + CNT_ONE;
      end
      if (state == COLLECT && partial) skew_err <= 1'b1;
      if (take && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            skew_err <= 1'b0;
            if (num_rows != '0) begin
              num_q  <= num_rows;
              wr_cnt <= '0;
              rd_cnt <= '0;
              state  <= COLLECT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (push) begin
            wr_cnt <= wr_cnt + CNT_ONE;
            if (wr_cnt + CNT_ONE == num_q) state <= DRAIN;
          end
        end
        default: ;
      endcase
      if (pop && out_last) begin
        done  <= 1'b1;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sys_array_output_collector.sv
// Self-checking bench for sys_array_output_collector: randomized rows against a row-queue reference model.
module tb_sys_array_output_collector;
  localparam int DATA_WIDTH = 8;
  localparam int COLS       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W      = 8;
  localparam int WW         = 2*DATA_WIDTH;
  localparam int RW         = COLS*WW;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [ROW_W-1:0] num_rows = '0;
  logic [COLS-1:0]  col_valid = '0;
  logic [RW-1:0]    col_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RW-1:0]    out_row;
  logic             out_last, busy, done, overflow, skew_err;

  int errors = 0;
  int checks = 0;

  logic [COLS-1:0] sv [64];
  logic [RW-1:0]   sd [64];

  sys_array_output_collector #(
    .DATA_WIDTH(DATA_WIDTH), .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_rows(num_rows),
    .col_valid(col_valid), .col_data(col_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] r);
    logic [RW-1:0] m = r;
`ifdef SYS_ARRAY_COLLECTOR_RELU_EN
    for (int j = 0; j < COLS; j++)
      if (r[j*WW+WW-1]) m[j*WW +: WW] = '0;
`endif
    return m;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*WW +: WW] = WW'($urandom);
    return r;
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < 64; k++) begin
      sv[k] = '0;
      sd[k] = rand_row();
    end
  endtask

  // Row whose column 0 is presented at cycle t; column j follows j cycles later.
  task automatic add_row(input int t, input logic [RW-1:0] r);
    for (int j = 0; j < COLS; j++) begin
      sv[t+j][j] = 1'b1;
      sd[t+j][j*WW +: WW] = r[j*WW +: WW];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    col_valid = sv[k];
    col_data  = sd[k];
  endtask

  task automatic do_start(input logic [ROW_W-1:0] n);
    start    = 1'b1;
    num_rows = n;
    next_cycle();
    start    = 1'b0;
    num_rows = ROW_W'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, overflow, skew_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {out_valid, out_last, busy, done, overflow, skew_err});
    end
    checks++;
    if (out_row !== '0) begin
      errors++;
      $display("FAIL reset_row got %h want 0", out_row);
    end
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    logic [RW-1:0] row;
    row = {16'd40, 16'd30, 16'd20, 16'd10};
    clear_sched();
    add_row(0, row);
    out_ready = 1'b1;
    do_start(1);
    for (int k = 0; k < 10; k++) begin
      drive(k);
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 5)) begin
        errors++;
        $display("FAIL single_valid k=%0d got %b want %b", k, out_valid, (k == 5));
      end
      checks++;
      if (done !== (k == 6)) begin
        errors++;
        $display("FAIL single_done k=%0d got %b want %b", k, done, (k == 6));
      end
      checks++;
      if (busy !== (k < 6)) begin
        errors++;
        $display("FAIL single_busy k=%0d got %b want %b", k, busy, (k < 6));
      end
      if (k == 5) begin
        checks++;
        if (out_row !== 64'h0028_001E_0014_000A) begin
          errors++;
          $display("FAIL single_row got %h want 0028001e0014000a", out_row);
        end
        checks++;
        if (out_last !== 1'b1) begin
          errors++;
          $display("FAIL single_last got %b want 1", out_last);
        end
      end
      next_cycle();
    end
    col_valid = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back(input int nrows, input bit rand_ready);
    logic [RW-1:0] rows [$];
    int            avail [$];
    int            n_out = 0;
    int            done_at = -1;
    bit            seen_done = 1'b0;
    bit            exp_v;
    logic [RW-1:0] r;
    clear_sched();
    for (int i = 0; i < nrows; i++) begin
      r = rand_row();
      add_row(i, r);
      rows.push_back(model_row(r));
      avail.push_back(i + COLS + 1);
    end
    out_ready = 1'b1;
    do_start(ROW_W'(nrows));
    for (int k = 0; k < 60 && !seen_done; k++) begin
      drive(k);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      exp_v = (rows.size() > 0) && (avail[0] <= k);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid k=%0d got %b want %b", k, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_row !== rows[0]) begin
          errors++;
          $display("FAIL b2b_row k=%0d got %h want %h", k, out_row, rows[0]);
        end
        checks++;
        if (out_last !== (n_out == nrows-1)) begin
          errors++;
          $display("FAIL b2b_last k=%0d got %b want %b", k, out_last, (n_out == nrows-1));
        end
      end
      checks++;
      if (done !== (k == done_at)) begin
        errors++;
        $display("FAIL b2b_done k=%0d got %b want %b", k, done, (k == done_at));
      end
      if (done === 1'b1) seen_done = 1'b1;
      if (exp_v && out_ready) begin
        if (n_out == nrows-1) done_at = k + 1;
        void'(rows.pop_front());
        void'(avail.pop_front());
        n_out++;
      end
      next_cycle();
    end
    checks++;
    if (!seen_done || rows.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout rows_left=%0d done_seen=%0b want 0 and 1", rows.size(), seen_done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_end got %b want 0", busy);
    end
    col_valid = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] rows [$];
    int            avail [$];
    int            n_out = 0;
    int            done_at = -1;
    bit            seen_done = 1'b0;
    bit            exp_v;
    logic [RW-1:0] r;
    clear_sched();
    // Rows 4 and 5 find the FIFO full and are dropped; two later rows complete the frame.
    for (int i = 0; i < 6; i++) begin
      r = rand_row();
      add_row(i, r);
      if (i < FIFO_DEPTH) begin
        rows.push_back(model_row(r));
        avail.push_back(i + COLS + 1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      r = rand_row();
      add_row(17 + i, r);
      rows.push_back(model_row(r));
      avail.push_back(17 + i + COLS + 1);
    end
    do_start(6);
    for (int k = 0; k < 60 && !seen_done; k++) begin
      drive(k);
      out_ready = (k >= 12);
      @(negedge clk);
      exp_v = (rows.size() > 0) && (avail[0] <= k);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL bp_valid k=%0d got %b want %b", k, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_row !== rows[0]) begin
          errors++;
          $display("FAIL bp_row k=%0d got %h want %h", k, out_row, rows[0]);
        end
        checks++;
        if (out_last !== (n_out == 5)) begin
          errors++;
          $display("FAIL bp_last k=%0d got %b want %b", k, out_last, (n_out == 5));
        end
      end
      checks++;
      if (overflow !== (k >= 9)) begin
        errors++;
        $display("FAIL bp_overflow k=%0d got %b want %b", k, overflow, (k >= 9));
      end
      checks++;
      if (done !== (k == done_at)) begin
        errors++;
        $display("FAIL bp_done k=%0d got %b want %b", k, done, (k == done_at));
      end
      if (k == 16) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL bp_busy_collect got %b want 1", busy);
        end
      end
      if (done === 1'b1) seen_done = 1'b1;
      if (exp_v && out_ready) begin
        if (n_out == 5) done_at = k + 1;
        void'(rows.pop_front());
        void'(avail.pop_front());
        n_out++;
      end
      next_cycle();
    end
    checks++;
    if (!seen_done || rows.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout rows_left=%0d done_seen=%0b want 0 and 1", rows.size(), seen_done);
    end
    col_valid = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_skew();
    logic [RW-1:0] r;
    bit            seen_done = 1'b0;
    r = rand_row();
    clear_sched();
    sv[0] = 4'b0001;
    add_row(10, r);
    out_ready = 1'b1;
    do_start(1);
    for (int k = 0; k < 30 && !seen_done; k++) begin
      drive(k);
      @(negedge clk);
      checks++;
      if (skew_err !== (k >= 5)) begin
        errors++;
        $display("FAIL skew_flag k=%0d got %b want %b", k, skew_err, (k >= 5));
      end
      checks++;
      if (out_valid !== (k == 15)) begin
        errors++;
        $display("FAIL skew_valid k=%0d got %b want %b", k, out_valid, (k == 15));
      end
      if (k == 15) begin
        checks++;
        if (out_row !== model_row(r)) begin
          errors++;
          $display("FAIL skew_row got %h want %h", out_row, model_row(r));
        end
      end
      if (done === 1'b1) seen_done = 1'b1;
      next_cycle();
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL skew_timeout done_seen=0 want 1");
    end
    col_valid = '0;
    do_start(0);
    checks++;
    if ({done, busy, skew_err} !== 3'b100) begin
      errors++;
      $display("FAIL zero_rows_start got done,busy,skew=%b want 100", {done, busy, skew_err});
    end
    next_cycle();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_rows_pulse got %b want 0", done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] r;
    clear_sched();
    add_row(0, rand_row());
    add_row(1, rand_row());
    out_ready = 1'b0;
    do_start(4);
    for (int k = 0; k < 8; k++) begin
      drive(k);
      next_cycle();
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got valid,busy=%b%b want 11", out_valid, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, overflow, skew_err} !== 6'b0 || out_row !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got flags=%b row=%h want 0", {out_valid, out_last, busy, done, overflow, skew_err}, out_row);
    end
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    r = rand_row();
    clear_sched();
    add_row(0, r);
    out_ready = 1'b1;
    do_start(1);
    for (int k = 0; k < 9; k++) begin
      drive(k);
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 5) || done !== (k == 6)) begin
        errors++;
        $display("FAIL midreset_frame k=%0d got valid,done=%b%b want %b%b", k, out_valid, done, (k == 5), (k == 6));
      end
      if (k == 5) begin
        checks++;
        if (out_row !== model_row(r) || out_last !== 1'b1) begin
          errors++;
          $display("FAIL midreset_row got %h last=%b want %h last=1", out_row, out_last, model_row(r));
        end
      end
      next_cycle();
    end
    col_valid = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_relu();
    logic [RW-1:0] row, want;
    row = 64'h0000_8000_0007_FFFB;
`ifdef SYS_ARRAY_COLLECTOR_RELU_EN
    want = 64'h0000_0000_0007_0000;
`else
    want = 64'h0000_8000_0007_FFFB;
`endif
    clear_sched();
    add_row(0, row);
    out_ready = 1'b1;
    do_start(1);
    for (int k = 0; k < 8; k++) begin
      drive(k);
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 5)) begin
        errors++;
        $display("FAIL relu_valid k=%0d got %b want %b", k, out_valid, (k == 5));
      end
      if (k == 5) begin
        checks++;
        if (out_row !== want) begin
          errors++;
          $display("FAIL relu_row got %h want %h", out_row, want);
        end
      end
      next_cycle();
    end
    col_valid = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back(3, 1'b0);
    test_back_to_back(4, 1'b1);
    test_backpressure();
    test_skew();
    test_reset_mid();
    test_relu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
